// File: rtl/seven_segment_scanner_if.sv
// Bundle between a host and the seven-segment scan driver: packed BCD value,
// capture strobe and blanking enable in; decoder nibble, digit enables and error flag out.
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic                    blank_lz;
  logic [3:0]              digit;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    bcd_err;

  modport master (
    output value, load, blank_lz,
    input  digit, digit_sel, bcd_err
  );

  modport slave (
    input  value, load, blank_lz,
    output digit, digit_sel, bcd_err
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scan driver for a multi-digit seven-segment display: holds a
// shadow copy of the BCD value and presents one digit slot at a time to the decoder.
module seven_segment_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input logic                    clk,
  input logic                    rst,
  seven_segment_scanner_if.slave bus
);
  localparam int VW    = 4 * NUM_DIGITS;
  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

  // High when any nibble of v lies outside 0..9.
  function automatic logic has_non_bcd(input logic [VW-1:0] v);
    logic err;
    err = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      err = err | (v[4*i +: 4] > 4'd9);
    end
    return err;
  endfunction

  logic [VW-1:0]         shadow_r;
  logic [DIV_W-1:0]      div_r;
  logic [IDX_W-1:0]      idx_r;
  logic [3:0]            digit_r;
  logic [NUM_DIGITS-1:0] sel_r;
  logic                  err_r;

  logic [3:0]            nib_s;
  logic                  upper_nz_s;
  logic                  blank_s;
  logic [3:0]            digit_nxt_s;
  logic [NUM_DIGITS-1:0] sel_nxt_s;

  // Next-slot outputs: current nibble, and whether this slot is a leading zero to blank.
  always_comb begin
    nib_s      = shadow_r[{idx_r, 2'b00} +: 4];
    upper_nz_s = 1'b0;
    // Any nonzero nibble at or above the current slot keeps it lit (interior zeros stay visible).
    for (int i = 0; i < NUM_DIGITS; i++) begin
      upper_nz_s = upper_nz_s | ((i >= int'(idx_r)) && (shadow_r[4*i +: 4] != 4'd0));
    end
    blank_s     = bus.blank_lz && (idx_r != {IDX_W{1'b0}}) && !upper_nz_s;
    digit_nxt_s = blank_s ? 4'd0 : nib_s;
    sel_nxt_s   = blank_s ? {NUM_DIGITS{1'b0}} : (SEL_ONE << idx_r);
  end

  // Refresh divider, scan index, shadow capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r <= {VW{1'b0}};
      div_r    <= {DIV_W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      digit_r  <= 4'd0;
      sel_r    <= {NUM_DIGITS{1'b0}};
      err_r    <= 1'b0;
    end else begin
      if (div_r == DIV_LAST) begin
        div_r <= {DIV_W{1'b0}};
        idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
      end else begin
        div_r <= div_r + DIV_W'(1);
        idx_r <= idx_r;
      end
      if (bus.load) begin
        shadow_r <= bus.value;
      end else begin
        shadow_r <= shadow_r;
      end
      digit_r <= digit_nxt_s;
      sel_r   <= sel_nxt_s;
      err_r   <= has_non_bcd(shadow_r);
    end
  end

  assign bus.digit     = digit_r;
  assign bus.digit_sel = sel_r;
  assign bus.bcd_err   = err_r;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (4 digits, 4-cycle slots): a per-edge
// vector table for reset and scan order, then hand-written multi-cycle sequences.
module tb_seven_segment_scanner;
  localparam int ND = 4;
  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seven_segment_scanner_if #(.NUM_DIGITS(ND)) bus ();

  seven_segment_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        blank;
    logic [3:0]  digit;
    logic [3:0]  sel;
    logic        err;
  } vec_t;

  vec_t tbl[20];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n     = 0;
  logic bl    = 1'b0;

  function automatic vec_t mk(input logic r, input logic ld, input logic [15:0] v,
                              input logic b, input logic [3:0] d, input logic [3:0] s,
                              input logic e);
    vec_t t;
    t.rst = r; t.load = ld; t.value = v; t.blank = b;
    t.digit = d; t.sel = s; t.err = e;
    return t;
  endfunction

  // Drive inputs, take one rising edge, and settle 1 time unit past it; n labels that edge.
  task automatic step(input logic r, input logic ld, input logic [15:0] v);
    rst          = r;
    bus.load     = ld;
    bus.value    = v;
    bus.blank_lz = bl;
    n++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_to(input int target);
    while (n < target) step(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic chk(input string name, input logic [3:0] d, input logic [3:0] s, input logic e);
    n_cmp += 3;
    if (bus.digit !== d) begin
      n_bad++;
      $display("FAIL %s (edge %0d): digit got %h expected %h", name, n, bus.digit, d);
    end
    if (bus.digit_sel !== s) begin
      n_bad++;
      $display("FAIL %s (edge %0d): digit_sel got %b expected %b", name, n, bus.digit_sel, s);
    end
    if (bus.bcd_err !== e) begin
      n_bad++;
      $display("FAIL %s (edge %0d): bcd_err got %b expected %b", name, n, bus.bcd_err, e);
    end
  endtask

  initial begin
    rst = 1'b1; bus.load = 1'b0; bus.value = 16'h0000; bus.blank_lz = 1'b0;

    // Three reset edges, then 1234 loaded on the release edge; slots 4,3,2,1 for 4 edges each.
    tbl[0]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 4'b0000, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 4'b0000, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 4'b0000, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 16'h1234, 1'b0, 4'h0, 4'b0001, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h4, 4'b0001, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h4, 4'b0001, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h4, 4'b0001, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h3, 4'b0010, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h3, 4'b0010, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h3, 4'b0010, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h3, 4'b0010, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h2, 4'b0100, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h2, 4'b0100, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h2, 4'b0100, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h2, 4'b0100, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h1, 4'b1000, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h1, 4'b1000, 1'b0);
    tbl[17] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h1, 4'b1000, 1'b0);
    tbl[18] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h1, 4'b1000, 1'b0);
    tbl[19] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 4'h4, 4'b0001, 1'b0);

    for (int i = 0; i < 20; i++) begin
      bl = tbl[i].blank;
      step(tbl[i].rst, tbl[i].load, tbl[i].value);
      chk($sformatf("table[%0d]", i), tbl[i].digit, tbl[i].sel, tbl[i].err);
    end
    n = 16;  // edge 0 is the first edge after reset release

    // Leading-zero blanking on 0050, then 0000, then 1005.
    bl = 1'b1;
    step(1'b0, 1'b1, 16'h0050);
    step(1'b0, 1'b0, 16'h0000);      chk("lz_0050_s0", 4'h0, 4'b0001, 1'b0);
    idle_to(20);                     chk("lz_0050_s1", 4'h5, 4'b0010, 1'b0);
    idle_to(24);                     chk("lz_0050_s2", 4'h0, 4'b0000, 1'b0);
    idle_to(28);                     chk("lz_0050_s3", 4'h0, 4'b0000, 1'b0);
    idle_to(31);
    step(1'b0, 1'b1, 16'h0000);      chk("lz_0050_wrap", 4'h0, 4'b0001, 1'b0);
    step(1'b0, 1'b0, 16'h0000);      chk("lz_0000_s0", 4'h0, 4'b0001, 1'b0);
    idle_to(36);                     chk("lz_0000_s1", 4'h0, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 16'h1005);      chk("lz_0000_s1_late", 4'h0, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 16'h0000);      chk("lz_1005_s1", 4'h0, 4'b0010, 1'b0);
    idle_to(40);                     chk("lz_1005_s2", 4'h0, 4'b0100, 1'b0);
    idle_to(44);                     chk("lz_1005_s3", 4'h1, 4'b1000, 1'b0);

    // Non-BCD nibble flagging and pass-through.
    bl = 1'b0;
    step(1'b0, 1'b1, 16'h12A4);      chk("err_load_edge", 4'h1, 4'b1000, 1'b0);
    step(1'b0, 1'b0, 16'h0000);      chk("err_set", 4'h1, 4'b1000, 1'b1);
    idle_to(48);                     chk("err_s0", 4'h4, 4'b0001, 1'b1);
    idle_to(52);                     chk("err_hex_s1", 4'hA, 4'b0010, 1'b1);
    step(1'b0, 1'b1, 16'h1294);      chk("err_clr_edge", 4'hA, 4'b0010, 1'b1);
    step(1'b0, 1'b0, 16'h0000);      chk("err_clr", 4'h9, 4'b0010, 1'b0);

    // Load mid-slot 2, then load on the edge that wraps slot 3 to slot 0.
    idle_to(57);
    step(1'b0, 1'b1, 16'h9876);      chk("mid_old", 4'h2, 4'b0100, 1'b0);
    step(1'b0, 1'b0, 16'h0000);      chk("mid_new", 4'h8, 4'b0100, 1'b0);
    step(1'b0, 1'b0, 16'h0000);      chk("mid_timing", 4'h9, 4'b1000, 1'b0);
    idle_to(62);
    step(1'b0, 1'b1, 16'h4321);      chk("wrap_old", 4'h9, 4'b1000, 1'b0);
    step(1'b0, 1'b0, 16'h0000);      chk("wrap_new_s0", 4'h1, 4'b0001, 1'b0);

    // Reset in slot 3 (with a competing load), then a full-length first slot.
    idle_to(76);                     chk("pre_rst_s3", 4'h4, 4'b1000, 1'b0);
    step(1'b1, 1'b1, 16'h7777);      chk("rst_mid", 4'h0, 4'b0000, 1'b0);
    n = -1;
    step(1'b0, 1'b0, 16'h0000);      chk("post_rst_s0", 4'h0, 4'b0001, 1'b0);
    idle_to(3);                      chk("post_rst_s0_end", 4'h0, 4'b0001, 1'b0);
    step(1'b0, 1'b0, 16'h0000);      chk("post_rst_s1", 4'h0, 4'b0010, 1'b0);

    // blank_lz toggles apply on the next edge.
    step(1'b0, 1'b1, 16'h0050);
    idle_to(8);                      chk("toggle_off", 4'h0, 4'b0100, 1'b0);
    bl = 1'b1;
    step(1'b0, 1'b0, 16'h0000);      chk("toggle_on", 4'h0, 4'b0000, 1'b0);
    bl = 1'b0;
    step(1'b0, 1'b0, 16'h0000);      chk("toggle_off2", 4'h0, 4'b0100, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
